// File: rtl/vc_test_delay_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : vc_test_delay_pkg
//  Purpose  : Shared constants for the val/rdy test delay element. Holds the
//             run-time mode codes, the FSM state encoding, the LFSR feedback
//             polynomial and a trace-character helper.
//  Revision : 1.0  initial release
// ============================================================================
package vc_test_delay_pkg;

    // Run-time delay modes, driven on the 'mode' port
    localparam logic [1:0] VC_DELAY_BYPASS = 2'd0;
    localparam logic [1:0] VC_DELAY_FIXED  = 2'd1;
    localparam logic [1:0] VC_DELAY_RANDOM = 2'd2;
    localparam logic [1:0] VC_DELAY_BURST  = 2'd3;

    // Delay FSM state encoding
    localparam int         c_ST_W     = 2;
    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_DELAY = 2'd1;
    localparam logic [1:0] c_ST_SEND  = 2'd2;

    // Right-shifting Galois feedback taps (maximal-length 16-bit sequence)
    localparam logic [15:0] c_LFSR_POLY = 16'hB400;

    // Trace character for a state, in the test library style:
    // ' ' idle, '#' delaying, '*' holding a message for the sink.
    function automatic logic [7:0] trace_char(input logic [c_ST_W-1:0] state);
        logic [7:0] ch;
        ch = 8'h20;
        case (state)
            c_ST_DELAY: ch = 8'h23;
            c_ST_SEND:  ch = 8'h2A;
            default:    ch = 8'h20;
        endcase
        return ch;
    endfunction

endpackage
`default_nettype wire

// File: rtl/vc_test_delay_ctrl_lfsr16.sv
`default_nettype none
// ============================================================================
//  Module   : vc_test_lfsr16
//  Purpose  : 16-bit right-shifting Galois LFSR used as the reproducible
//             random source for the delay element. Advances one step per
//             cycle while 'en' is high.
//  Ports    : clk    - clock, rising edge
//             reset  - asynchronous, active-low reset (loads p_seed)
//             en     - advance enable
//             state  - current 16-bit LFSR value
//  Revision : 1.0  initial release
// ============================================================================
module vc_test_lfsr16
    import vc_test_delay_pkg::*;
#(
    parameter logic [15:0] p_seed = 16'hACE1
)(
    input  logic        clk,
    input  logic        reset,
    input  logic        en,
    output logic [15:0] state
);

    // An all-zero seed locks the LFSR at zero forever
    generate
        if (p_seed == 16'h0000) begin : g_seed_check
            $fatal(1, "vc_test_lfsr16: p_seed must be nonzero");
        end
    endgenerate

    logic [15:0] r_lfsr;
    logic [15:0] w_lfsr_nxt;

    always_comb begin
        w_lfsr_nxt = {1'b0, r_lfsr[15:1]} ^ (r_lfsr[0] ? c_LFSR_POLY : 16'h0000);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_lfsr <= p_seed;
        end else if (en) begin
            r_lfsr <= w_lfsr_nxt;
        end
    end

    assign state = r_lfsr;

endmodule
`default_nettype wire

// File: rtl/vc_test_delay_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : vc_test_delay_ctrl
//  Purpose  : val/rdy delay element for test benches. Holds one message and
//             releases it after a per-message delay chosen by the run-time
//             mode: bypass (combinational pass-through), fixed, uniform
//             random, or bursty. Counts every downstream transfer.
//  Ports    : clk        - clock, rising edge
//             reset      - asynchronous, active-low reset
//             mode       - 0 bypass, 1 fixed, 2 random, 3 burst
//             max_delay  - delay bound D in cycles
//             in_val/in_rdy/in_msg    - upstream handshake and payload
//             out_val/out_rdy/out_msg - downstream handshake and payload
//             num_msgs   - count of out_val && out_rdy transfers (wraps)
//  Revision : 1.0  initial release
// ============================================================================
module vc_test_delay_ctrl
    import vc_test_delay_pkg::*;
#(
    parameter int          p_msg_nbits   = 8,
    parameter int          p_delay_nbits = 8,
    parameter logic [15:0] p_seed        = 16'hACE1
)(
    input  logic                     clk,
    input  logic                     reset,
    input  logic [1:0]               mode,
    input  logic [p_delay_nbits-1:0] max_delay,
    input  logic                     in_val,
    output logic                     in_rdy,
    input  logic [p_msg_nbits-1:0]   in_msg,
    output logic                     out_val,
    input  logic                     out_rdy,
    output logic [p_msg_nbits-1:0]   out_msg,
    output logic [31:0]              num_msgs
);

    // Wide enough for the 16-bit LFSR times (D+1) with D all-ones
    localparam int                       c_PROD_W    = p_delay_nbits + 17;
    localparam logic [p_delay_nbits-1:0] c_DELAY_ONE = p_delay_nbits'(1);

    logic [c_ST_W-1:0]        r_state;
    logic [c_ST_W-1:0]        w_state_nxt;
    logic [p_delay_nbits-1:0] r_count;
    logic [p_delay_nbits-1:0] w_count_nxt;
    logic [p_msg_nbits-1:0]   r_msg;
    logic [31:0]              r_num_msgs;

    logic                     w_bypass;
    logic                     w_idle;
    logic                     w_send;
    logic                     w_accept;
    logic [15:0]              w_lfsr;
    logic [c_PROD_W-1:0]      w_prod;
    logic [p_delay_nbits-1:0] w_rand_delay;
    logic [p_delay_nbits-1:0] w_delay;
    logic                     w_unused_prod;

    assign w_bypass = (mode == VC_DELAY_BYPASS);
    assign w_idle   = (r_state == c_ST_IDLE);
    assign w_send   = (r_state == c_ST_SEND);

    // ------------------------------------------------------------------------
    // Handshake outputs. Bypass only takes effect once the buffer is empty;
    // a message already held keeps upstream stalled until it drains.
    // ------------------------------------------------------------------------
    assign in_rdy  = (w_idle && !w_bypass)
                   || (w_send && out_rdy && !w_bypass)
                   || (w_idle && w_bypass && out_rdy);
    assign out_val = w_send || (w_idle && w_bypass && in_val);
    assign out_msg = (w_idle && w_bypass) ? in_msg : r_msg;

    // A message is captured only outside bypass; pass-through never loads
    assign w_accept = in_val && in_rdy && !w_bypass;

    // ------------------------------------------------------------------------
    // Random source: one step per captured message, frozen otherwise, so the
    // delay sequence depends only on the number of messages since reset.
    // ------------------------------------------------------------------------
    vc_test_lfsr16 #(
        .p_seed (p_seed)
    ) u_lfsr (
        .clk    (clk),
        .reset  (reset),
        .en     (w_accept),
        .state  (w_lfsr)
    );

    // Uniform scaling: floor(lfsr * (D+1) / 2^16) lies in [0, D]
    always_comb begin
        w_prod = {{(p_delay_nbits + 1){1'b0}}, w_lfsr}
               * ({17'b0, max_delay} + c_PROD_W'(1));
    end

    assign w_rand_delay  = w_prod[16 +: p_delay_nbits];
    assign w_unused_prod = ^{w_prod[15:0], w_prod[c_PROD_W-1]};

    // Delay for the message being captured this cycle
    always_comb begin
        w_delay = '0;
        case (mode)
            VC_DELAY_FIXED:  w_delay = max_delay;
            VC_DELAY_RANDOM: w_delay = w_rand_delay;
            VC_DELAY_BURST:  w_delay = (w_lfsr[15:13] == 3'b000) ? max_delay : '0;
            default:         w_delay = '0;
        endcase
    end

    // ------------------------------------------------------------------------
    // Delay FSM. The counter is loaded with d and SEND is entered on the
    // cycle after it reads 1, which puts out_val at accept + 1 + d.
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_count_nxt = r_count;
        case (r_state)
            c_ST_IDLE: begin
                if (w_accept) begin
                    w_count_nxt = w_delay;
                    w_state_nxt = (w_delay == '0) ? c_ST_SEND : c_ST_DELAY;
                end
            end
            c_ST_DELAY: begin
                if (r_count <= c_DELAY_ONE) begin
                    w_count_nxt = '0;
                    w_state_nxt = c_ST_SEND;
                end else begin
                    w_count_nxt = r_count - c_DELAY_ONE;
                end
            end
            c_ST_SEND: begin
                if (out_rdy) begin
                    // Same-cycle refill keeps one message per cycle at d == 0
                    if (w_accept) begin
                        w_count_nxt = w_delay;
                        w_state_nxt = (w_delay == '0) ? c_ST_SEND : c_ST_DELAY;
                    end else begin
                        w_state_nxt = c_ST_IDLE;
                    end
                end
            end
            default: begin
                w_count_nxt = '0;
                w_state_nxt = c_ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= c_ST_IDLE;
            r_count <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_count <= w_count_nxt;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_msg <= '0;
        end else if (w_accept) begin
            r_msg <= in_msg;
        end
    end

    // Counts pass-through transfers as well as buffered ones
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_num_msgs <= '0;
        end else if (out_val && out_rdy) begin
            r_num_msgs <= r_num_msgs + 32'd1;
        end
    end

    assign num_msgs = r_num_msgs;

endmodule
`default_nettype wire

// File: tb/tb_vc_test_delay_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_vc_test_delay_ctrl
//  Purpose  : Self-checking bench for vc_test_delay_ctrl. A negedge monitor
//             holds a transaction-level model (ordered message list, per
//             message due cycle, reference LFSR) and checks every cycle;
//             scenario tasks drive randomized val/rdy traffic.
//  Revision : 1.0  initial release
// ============================================================================
module tb_vc_test_delay_ctrl;
    import vc_test_delay_pkg::*;

    localparam int          MW      = 8;
    localparam int          DW      = 8;
    localparam logic [15:0] SEED    = 16'hACE1;
    localparam int          TIMEOUT = 5000;

    logic          clk = 1'b0;
    logic          reset;
    logic [1:0]    mode;
    logic [DW-1:0] max_delay;
    logic          in_val;
    logic          in_rdy;
    logic [MW-1:0] in_msg;
    logic          out_val;
    logic          out_rdy;
    logic [MW-1:0] out_msg;
    logic [31:0]   num_msgs;

    int errors = 0;
    int checks = 0;

    vc_test_delay_ctrl #(
        .p_msg_nbits   (MW),
        .p_delay_nbits (DW),
        .p_seed        (SEED)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .mode      (mode),
        .max_delay (max_delay),
        .in_val    (in_val),
        .in_rdy    (in_rdy),
        .in_msg    (in_msg),
        .out_val   (out_val),
        .out_rdy   (out_rdy),
        .out_msg   (out_msg),
        .num_msgs  (num_msgs)
    );

    always #5 clk = ~clk;

    // ------------------------------------------------------------------------
    // Reference model
    // ------------------------------------------------------------------------
    function automatic logic [15:0] m_next(input logic [15:0] s);
        return (s >> 1) ^ (s[0] ? 16'hB400 : 16'h0000);
    endfunction

    function automatic int m_delay(input logic [1:0] md, input int d, input logic [15:0] s);
        case (md)
            VC_DELAY_FIXED:  return d;
            VC_DELAY_RANDOM: return int'((longint'(s) * longint'(d + 1)) / 65536);
            VC_DELAY_BURST:  return (s < 16'h2000) ? d : 0;
            default:         return 0;
        endcase
    endfunction

    typedef struct {
        int acc;
        int due;
    } ent_t;

    ent_t          tq[$];     // buffered messages: accept cycle and due cycle
    logic [MW-1:0] oq[$];     // every accepted message, in order
    int            lat_log[$];
    logic [15:0]   m_lfsr;
    bit            mon_en = 1'b0;
    bit            front_seen;
    int            cyc;
    int            n_xfer;
    logic          ev;
    logic          er;
    int            md;
    logic [MW-1:0] msg_base;

    always @(negedge clk) begin
        if (mon_en) begin
            if (tq.size() != 0) begin
                ev = (cyc >= tq[0].due);
                er = ev && out_rdy && (mode != VC_DELAY_BYPASS);
            end else if (mode == VC_DELAY_BYPASS) begin
                ev = in_val;
                er = out_rdy;
            end else begin
                ev = 1'b0;
                er = 1'b1;
            end
            checks++;
            if (out_val !== ev) begin
                errors++;
                $display("FAIL out_val cyc=%0d got=%b exp=%b", cyc, out_val, ev);
            end
            checks++;
            if (in_rdy !== er) begin
                errors++;
                $display("FAIL in_rdy cyc=%0d got=%b exp=%b", cyc, in_rdy, er);
            end
            if (out_val === 1'b1 && tq.size() != 0 && !front_seen) begin
                front_seen = 1'b1;
                lat_log.push_back(cyc - tq[0].acc - 1);
            end
            if (in_val === 1'b1 && in_rdy === 1'b1) begin
                oq.push_back(in_msg);
                if (mode != VC_DELAY_BYPASS) begin
                    md = m_delay(mode, int'(max_delay), m_lfsr);
                    m_lfsr = m_next(m_lfsr);
                    tq.push_back('{acc: cyc, due: cyc + 1 + md});
                end
            end
            if (out_val === 1'b1) begin
                checks++;
                if (oq.size() == 0) begin
                    errors++;
                    $display("FAIL out_msg cyc=%0d got=%h exp=none", cyc, out_msg);
                end else if (out_msg !== oq[0]) begin
                    errors++;
                    $display("FAIL out_msg cyc=%0d got=%h exp=%h", cyc, out_msg, oq[0]);
                end
                if (out_rdy === 1'b1) begin
                    if (oq.size() != 0) void'(oq.pop_front());
                    if (tq.size() != 0) begin
                        void'(tq.pop_front());
                        front_seen = 1'b0;
                    end
                    n_xfer++;
                end
            end
            cyc++;
        end
    end

    // ------------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------------
    task automatic do_reset();
        mon_en = 1'b0;
        @(posedge clk); #1;
        reset   = 1'b0;
        in_val  = 1'b0;
        out_rdy = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        tq.delete();
        oq.delete();
        lat_log.delete();
        m_lfsr     = SEED;
        front_seen = 1'b0;
        cyc        = 0;
        n_xfer     = 0;
        mon_en     = 1'b1;
    endtask

    // Cycle indices (first_acc, last_del) count from the first driven cycle
    task automatic run_stream(input int n, input int val_pct, input int rdy_pct,
                              input int stall_at, input int stall_len,
                              input int sw_at, input logic [1:0] sw_mode,
                              output int cycles, output int first_acc, output int last_del);
        int sent;
        int got;
        bit fi;
        bit fo;
        sent = 0; got = 0; cycles = 0; first_acc = -1; last_del = -1;
        @(posedge clk); #1;
        in_val  = (int'($urandom_range(99)) < val_pct);
        in_msg  = msg_base;
        out_rdy = (int'($urandom_range(99)) < rdy_pct);
        while (got < n && cycles < TIMEOUT) begin
            @(negedge clk);
            fi = in_val && in_rdy;
            fo = out_val && out_rdy;
            if (fi && first_acc < 0) first_acc = cycles;
            if (fo) last_del = cycles;
            @(posedge clk); #1;
            if (fi) sent++;
            if (fo) got++;
            cycles++;
            if (cycles == sw_at) mode = sw_mode;
            in_val  = (sent < n) && (int'($urandom_range(99)) < val_pct);
            in_msg  = msg_base + MW'(sent);
            out_rdy = !(cycles >= stall_at && cycles < stall_at + stall_len)
                      && (int'($urandom_range(99)) < rdy_pct);
        end
        in_val   = 1'b0;
        msg_base = msg_base + MW'(n);
        checks++;
        if (got < n) begin
            errors++;
            $display("FAIL stream_timeout got=%0d exp=%0d", got, n);
        end
    endtask

    // ------------------------------------------------------------------------
    // Scenarios
    // ------------------------------------------------------------------------
    task automatic test_reset();
        mode = VC_DELAY_FIXED;
        max_delay = 8'd3;
        do_reset();
        checks++;
        if (out_val !== 1'b0) begin errors++; $display("FAIL reset_out_val got=%b exp=0", out_val); end
        checks++;
        if (in_rdy !== 1'b1) begin errors++; $display("FAIL reset_in_rdy got=%b exp=1", in_rdy); end
        checks++;
        if (num_msgs !== 32'd0) begin errors++; $display("FAIL reset_num_msgs got=%0d exp=0", num_msgs); end
        checks++;
        if (dut.u_lfsr.state !== SEED) begin errors++; $display("FAIL reset_lfsr got=%h exp=%h", dut.u_lfsr.state, SEED); end
    endtask

    task automatic test_bypass();
        int c, fa, ld;
        mode = VC_DELAY_BYPASS;
        do_reset();
        run_stream(16, 100, 100, 0, 0, -1, VC_DELAY_BYPASS, c, fa, ld);
        checks++;
        if (c !== 16) begin errors++; $display("FAIL bypass_cycles got=%0d exp=16", c); end
        checks++;
        if (num_msgs !== 32'd16) begin errors++; $display("FAIL bypass_num_msgs got=%0d exp=16", num_msgs); end
        checks++;
        if (dut.u_lfsr.state !== SEED) begin errors++; $display("FAIL bypass_lfsr_frozen got=%h exp=%h", dut.u_lfsr.state, SEED); end
    endtask

    // Message k is accepted at 4k and first valid at 4k+4; the last one at 64
    task automatic test_fixed();
        int c, fa, ld;
        mode = VC_DELAY_FIXED;
        max_delay = 8'd3;
        do_reset();
        run_stream(16, 100, 100, 0, 0, -1, VC_DELAY_FIXED, c, fa, ld);
        checks++;
        if (ld - fa !== 64) begin errors++; $display("FAIL fixed_span got=%0d exp=64", ld - fa); end
        checks++;
        if (num_msgs !== 32'd16) begin errors++; $display("FAIL fixed_num_msgs got=%0d exp=16", num_msgs); end
    endtask

    task automatic test_random();
        int c, fa, ld;
        int saved[$];
        mode = VC_DELAY_RANDOM;
        max_delay = 8'd10;
        do_reset();
        run_stream(16, 70, 70, 0, 0, -1, VC_DELAY_RANDOM, c, fa, ld);
        checks++;
        if (num_msgs !== 32'd16) begin errors++; $display("FAIL random_num_msgs got=%0d exp=16", num_msgs); end
        checks++;
        if (lat_log.size() != 16) begin errors++; $display("FAIL random_lat_count got=%0d exp=16", lat_log.size()); end
        foreach (lat_log[i]) begin
            checks++;
            if (lat_log[i] < 0 || lat_log[i] > 10) begin
                errors++;
                $display("FAIL random_range idx=%0d got=%0d exp=0..10", i, lat_log[i]);
            end
        end
        saved = lat_log;
        do_reset();
        run_stream(16, 70, 70, 0, 0, -1, VC_DELAY_RANDOM, c, fa, ld);
        checks++;
        if (lat_log.size() != saved.size()) begin
            errors++;
            $display("FAIL random_repeat_len got=%0d exp=%0d", lat_log.size(), saved.size());
        end else begin
            foreach (saved[i]) begin
                checks++;
                if (lat_log[i] != saved[i]) begin
                    errors++;
                    $display("FAIL random_repeat idx=%0d got=%0d exp=%0d", i, lat_log[i], saved[i]);
                end
            end
        end
    endtask

    task automatic test_burst();
        int c, fa, ld;
        mode = VC_DELAY_BURST;
        max_delay = 8'd20;
        do_reset();
        run_stream(16, 100, 100, 8, 5, -1, VC_DELAY_BURST, c, fa, ld);
        checks++;
        if (num_msgs !== 32'd16) begin errors++; $display("FAIL burst_num_msgs got=%0d exp=16", num_msgs); end
        checks++;
        if (n_xfer !== 16) begin errors++; $display("FAIL burst_xfers got=%0d exp=16", n_xfer); end
    endtask

    // msg0 accepted at 0 with d=5 -> delivered at 6; bypass then passes
    // msgs 1..3 at cycles 7, 8, 9
    task automatic test_switch_bypass();
        int c, fa, ld;
        mode = VC_DELAY_FIXED;
        max_delay = 8'd5;
        do_reset();
        run_stream(4, 100, 100, 0, 0, 2, VC_DELAY_BYPASS, c, fa, ld);
        checks++;
        if (ld !== 9) begin errors++; $display("FAIL switch_last_delivery got=%0d exp=9", ld); end
        checks++;
        if (num_msgs !== 32'd4) begin errors++; $display("FAIL switch_num_msgs got=%0d exp=4", num_msgs); end
    endtask

    task automatic test_reset_mid();
        int c, fa, ld;
        mode = VC_DELAY_FIXED;
        max_delay = 8'd1;
        do_reset();
        run_stream(2, 100, 100, 0, 0, -1, VC_DELAY_FIXED, c, fa, ld);
        max_delay = 8'd8;
        @(posedge clk); #1;
        in_val = 1'b1;
        in_msg = 8'hA5;
        @(posedge clk); #1;
        in_val = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        mon_en = 1'b0;
        reset  = 1'b0;
        #1;
        checks++;
        if (out_val !== 1'b0) begin errors++; $display("FAIL midreset_out_val got=%b exp=0", out_val); end
        checks++;
        if (num_msgs !== 32'd0) begin errors++; $display("FAIL midreset_num_msgs got=%0d exp=0", num_msgs); end
        checks++;
        if (dut.u_lfsr.state !== SEED) begin errors++; $display("FAIL midreset_lfsr got=%h exp=%h", dut.u_lfsr.state, SEED); end
        checks++;
        if (in_rdy !== 1'b1) begin errors++; $display("FAIL midreset_in_rdy got=%b exp=1", in_rdy); end
        max_delay = 8'd2;
        do_reset();
        run_stream(16, 80, 60, 0, 0, -1, VC_DELAY_FIXED, c, fa, ld);
        checks++;
        if (num_msgs !== 32'd16) begin errors++; $display("FAIL midreset_restart got=%0d exp=16", num_msgs); end
    endtask

    // D all-ones exercises the widest scaling product; D=0 forces d=0,
    // so 8 back-to-back messages are first valid at cycles 1..8
    task automatic test_delay_bounds();
        int c, fa, ld;
        mode = VC_DELAY_RANDOM;
        max_delay = 8'hFF;
        do_reset();
        run_stream(6, 100, 100, 0, 0, -1, VC_DELAY_RANDOM, c, fa, ld);
        checks++;
        if (num_msgs !== 32'd6) begin errors++; $display("FAIL maxd_num_msgs got=%0d exp=6", num_msgs); end
        max_delay = 8'd0;
        do_reset();
        run_stream(8, 100, 100, 0, 0, -1, VC_DELAY_RANDOM, c, fa, ld);
        checks++;
        if (ld - fa !== 8) begin errors++; $display("FAIL zerod_span got=%0d exp=8", ld - fa); end
    endtask

    initial begin
        reset     = 1'b1;
        mode      = VC_DELAY_FIXED;
        max_delay = '0;
        in_val    = 1'b0;
        in_msg    = '0;
        out_rdy   = 1'b0;
        msg_base  = 8'h10;
        test_reset();
        test_bypass();
        test_fixed();
        test_random();
        test_burst();
        test_switch_bypass();
        test_reset_mid();
        test_delay_bounds();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
